// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int MODE_MEALY  = 0;
  localparam int MODE_MOORE  = 1;
  localparam int MAX_PAT_LEN = 16;

  // Default pattern for the 5-bit configuration; MSB is the oldest bit.
  localparam logic [4:0] DEFAULT_PATTERN = 5'b10010;

  // Compare the low 'len' bits of two zero-extended patterns.
  function automatic logic pat_equal(input logic [MAX_PAT_LEN-1:0] a,
                                     input logic [MAX_PAT_LEN-1:0] b,
                                     input int len);
    logic eq;
    eq = 1'b1;
    for (int i = 0; i < MAX_PAT_LEN; i++)
      if (i < len && a[i] != b[i]) eq = 1'b0;
    return eq;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // Count up on inc, stick at all-ones, clear on rst or clr.
  always_ff @(posedge clk) begin
    if (rst)                       cnt <= '0;
    else if (clr)                  cnt <= '0;
    else if (inc && (cnt != '1))   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector: reloadable pattern, Mealy/Moore
// output timing, overlapping/non-overlapping matches, saturating match count.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEFAULT_PATTERN),
  parameter int                 MOORE   = MODE_MEALY,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               J,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               w,
  output logic [CNT_W-1:0]   match_cnt,
  input  logic               cnt_clr
);

  localparam int FILL_W = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_reg;
  logic [PAT_LEN-2:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] window;
  logic               hit;

  // Candidate window: stored history with the current bit appended as LSB.
  assign window = {hist, J};

  // A hit needs a full history, an accepted bit and no pattern reload this cycle.
  assign hit = en & ~pat_load & (fill == FILL_MAX) &
               pat_equal(MAX_PAT_LEN'(window), MAX_PAT_LEN'(pat_reg), PAT_LEN);

  // Pattern register, history shift and fill level; rst > pat_load > en.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_reg <= PATTERN;
      hist    <= '0;
      fill    <= '0;
    end else if (pat_load) begin
      pat_reg <= pat_in;
      hist    <= '0;
      fill    <= '0;
    end else if (en) begin
      if (hit && (OVERLAP == 0)) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= window[PAT_LEN-2:0];
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .clr (cnt_clr),
    .cnt (match_cnt)
  );

  generate
    if (MOORE == MODE_MOORE) begin : g_moore
      logic w_q;
      // Registered match pulse, one cycle after the final bit.
      always_ff @(posedge clk) begin
        if (rst) w_q <= 1'b0;
        else     w_q <= hit;
      end
      assign w = w_q;
    end else begin : g_mealy
      assign w = hit & ~rst;
    end
  endgenerate

endmodule
